// File: rtl/game_dumper.sv
// ---------------------------------------------------------------------------
// game_dumper
//
// Streams a loaded game out of cartridge RAM as an iNES image: a 16-byte
// header synthesized from the loader's mapper_flags word, then the PRG region
// (base 0), then the CHR region (base 22'h200000, skipped for CHR-RAM games).
//
// Optional build macro: GAME_DUMPER_NES2_EN
//   defined   -> header byte 7 carries the NES 2.0 identifier ({hi, 4'b1000})
//   undefined -> plain iNES byte 7 ({hi, 4'b0000})
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   start          one-cycle start pulse, honoured only when idle or done
//   mapper_flags   [3:0] mapper lo, [7:4] mapper hi, [10:8] prg_size,
//                  [13:11] chr_size, [14] mirroring, [15] has_chr_ram
//   mem_addr       memory read address
//   mem_read       one-cycle read request
//   mem_rvalid     read data valid (>=1 cycle after mem_read)
//   mem_data       read data
//   outdata        stream byte
//   outdata_valid  stream byte available
//   outdata_ready  sink accepts (transfer on valid && ready)
//   busy           dump in progress (header / PRG / CHR)
//   done           last byte transferred; cleared by the next accepted start
// ---------------------------------------------------------------------------
module game_dumper #(
    parameter int ADDR_W = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       mapper_flags,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic              mem_rvalid,
    input  logic [7:0]        mem_data,
    output logic [7:0]        outdata,
    output logic              outdata_valid,
    input  logic              outdata_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] CHR_BASE = ADDR_W'(32'h0020_0000);

`ifdef GAME_DUMPER_NES2_EN
    localparam logic [3:0] HDR7_LO = 4'b1000;
`else
    localparam logic [3:0] HDR7_LO = 4'b0000;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PRG,
        S_CHR,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [15:0]         r_flags;
    logic [3:0]          r_hdr_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_bytes_left;
    logic [7:0]          r_outdata;
    logic                r_valid;
    logic                r_pending;
    logic                r_done;

    state_t              w_state_next;
    logic [15:0]         w_flags_next;
    logic [3:0]          w_hdr_idx_next;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [ADDR_W-1:0]   w_bytes_left_next;
    logic [7:0]          w_outdata_next;
    logic                w_valid_next;
    logic                w_pending_next;
    logic                w_done_next;

    logic                w_xfer;
    logic                w_fetch;
    logic                w_start_ok;
    logic [ADDR_W-1:0]   w_prg_len;
    logic [ADDR_W-1:0]   w_chr_len;

    // Only the low half of the flags word carries header/layout information.
    logic                w_unused_flags;
    assign w_unused_flags = ^mapper_flags[31:16];

    // Header byte for a given index, built from a flags word.
    function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [15:0] f);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            4'd0:    b = 8'h4E;
            4'd1:    b = 8'h45;
            4'd2:    b = 8'h53;
            4'd3:    b = 8'h1A;
            4'd4:    b = 8'd1 << f[10:8];
            4'd5:    b = f[15] ? 8'h00 : (8'd1 << f[13:11]);
            4'd6:    b = {f[3:0], 3'b000, f[14]};
            4'd7:    b = {f[7:4], HDR7_LO};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign w_prg_len  = ADDR_W'(32'd16384 << r_flags[10:8]);
    assign w_chr_len  = ADDR_W'(32'd8192 << r_flags[13:11]);
    assign w_xfer     = r_valid && outdata_ready;
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // A read goes out only with the output slot empty and nothing in flight,
    // which keeps exactly one byte between memory and the sink.
    assign w_fetch = ((r_state == S_PRG) || (r_state == S_CHR)) &&
                     !r_pending && !r_valid && (r_bytes_left != '0);

    always_comb begin
        w_state_next      = r_state;
        w_flags_next      = r_flags;
        w_hdr_idx_next    = r_hdr_idx;
        w_addr_next       = r_addr;
        w_bytes_left_next = r_bytes_left;
        w_outdata_next    = r_outdata;
        w_valid_next      = r_valid;
        w_pending_next    = r_pending;
        w_done_next       = r_done;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    // Byte 0 is presented straight away so it is valid the
                    // cycle after start.
                    w_flags_next   = mapper_flags[15:0];
                    w_done_next    = 1'b0;
                    w_hdr_idx_next = 4'd0;
                    w_outdata_next = hdr_byte(4'd0, mapper_flags[15:0]);
                    w_valid_next   = 1'b1;
                    w_state_next   = S_HEADER;
                end
            end

            S_HEADER: begin
                if (w_xfer) begin
                    if (r_hdr_idx == 4'd15) begin
                        w_valid_next      = 1'b0;
                        w_addr_next       = '0;
                        w_bytes_left_next = w_prg_len;
                        w_state_next      = S_PRG;
                    end else begin
                        w_hdr_idx_next = r_hdr_idx + 4'd1;
                        w_outdata_next = hdr_byte(r_hdr_idx + 4'd1, r_flags);
                    end
                end
            end

            S_PRG, S_CHR: begin
                if (w_fetch) begin
                    w_pending_next = 1'b1;
                end
                // Responses with nothing in flight are stray and dropped.
                if (r_pending && mem_rvalid) begin
                    w_outdata_next    = mem_data;
                    w_valid_next      = 1'b1;
                    w_addr_next       = r_addr + 1'b1;
                    w_bytes_left_next = r_bytes_left - 1'b1;
                    w_pending_next    = 1'b0;
                end
                if (w_xfer) begin
                    w_valid_next = 1'b0;
                    // bytes_left already counted this byte when it was loaded.
                    if (r_bytes_left == '0) begin
                        if ((r_state == S_PRG) && !r_flags[15]) begin
                            w_addr_next       = CHR_BASE;
                            w_bytes_left_next = w_chr_len;
                            w_state_next      = S_CHR;
                        end else begin
                            w_done_next  = 1'b1;
                            w_state_next = S_DONE;
                        end
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_flags      <= '0;
            r_hdr_idx    <= '0;
            r_addr       <= '0;
            r_bytes_left <= '0;
            r_outdata    <= '0;
            r_valid      <= 1'b0;
            r_pending    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_flags      <= w_flags_next;
            r_hdr_idx    <= w_hdr_idx_next;
            r_addr       <= w_addr_next;
            r_bytes_left <= w_bytes_left_next;
            r_outdata    <= w_outdata_next;
            r_valid      <= w_valid_next;
            r_pending    <= w_pending_next;
            r_done       <= w_done_next;
        end
    end

    assign mem_addr      = r_addr;
    assign mem_read      = w_fetch;
    assign outdata       = r_outdata;
    assign outdata_valid = r_valid;
    assign busy          = (r_state == S_HEADER) || (r_state == S_PRG) || (r_state == S_CHR);
    assign done          = r_done;

endmodule

// File: doc/game_dumper.md
# game_dumper

Serializes a loaded game from cartridge RAM back into an iNES byte stream: a synthesized 16-byte header, then the PRG region, then the CHR region. It is the transmit-side counterpart of the loader path. It sits between the shared PRG/CHR memory and a byte-wide outbound link such as a UART or SPI bridge, and is driven by the same `mapper_flags` word the loader produces.

## Interface

Parameters:
- `ADDR_W`, 22, memory address width; PRG base 0, CHR base `22'h200000`.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- `mapper_flags`  in  32  sampled on accepted `start`. Fields:
  - [3:0] mapper low nibble
  - [7:4] mapper high nibble
  - [10:8] prg_size (log2 of 16 KiB banks)
  - [13:11] chr_size (log2 of 8 KiB banks)
  - [14] mirroring
  - [15] has_chr_ram
- `mem_addr`  out  22  read address.
- `mem_read`  out  1  one-cycle read request.
- `mem_rvalid`  in  1  read data valid; arrives any number of cycles ≥1 after `mem_read`.
- `mem_data`  in  8  read data, qualified by `mem_rvalid`.
- `outdata`  out  8  stream byte.
- `outdata_valid`  out  1  byte available.
- `outdata_ready`  in  1  sink accepts; transfer when valid && ready.
- `busy`  out  1  high in HEADER/PRG/CHR.
- `done`  out  1  high after the last byte transfers; cleared by the next accepted `start`.

## Operation

- States: IDLE → HEADER → PRG → (CHR) → DONE. DONE goes back to HEADER on `start`.
- On accepted `start`:
  - latch the flags;
  - clear `done`;
  - set the header index to 0;
  - enter HEADER.
- HEADER emits 16 bytes from the latched flags, in order:
  - bytes 0–3: `4E 45 53 1A`.
  - byte 4: `1 << prg_size`.
  - byte 5: `has_chr_ram ? 0 : 1 << chr_size`.
  - byte 6: `{mapper_lo, 3'b000, mirroring}`. No trainer, no battery, no alternate nametables.
  - byte 7: `{mapper_hi, 4'b0000}`.
  - bytes 8–15: `00`.
- After byte 15 transfers:
  - set `mem_addr` = 0;
  - set `bytes_left` = `16384 << prg_size` (22-bit, max 2 MiB);
  - enter PRG.
- PRG/CHR fetch:
  - Issue `mem_read` only when no read is outstanding, `outdata_valid` = 0, and `bytes_left` ≠ 0.
  - On `mem_rvalid`: load `outdata`, assert `outdata_valid`, increment `mem_addr`, decrement `bytes_left`.
  - At most one read is outstanding at any time.
- PRG exit, after the last PRG byte transfers:
  - If `has_chr_ram` = 1, go directly to DONE.
  - Otherwise set `mem_addr` = `22'h200000` and `bytes_left` = `8192 << chr_size`, then enter CHR.
- CHR exit: after the last CHR byte transfers, enter DONE with `done` = 1.
- Ignored inputs:
  - `start` while `busy`.
  - `mem_rvalid` with no read outstanding.
- `outdata`, `mem_addr`, `mem_read` and the internal counters are don't-care outside the states where they are used, but must be deterministic.

## Timing

- Reset values:
  - state = IDLE
  - `busy`, `done`, `outdata_valid`, `mem_read` = 0
  - `outdata` = 0, `mem_addr` = 0
  - `bytes_left` = 0, header index = 0
- Reset asserted mid-operation aborts immediately. No further `mem_read` pulses. A read response arriving after reset release is ignored.
- Header latency and rate:
  - header byte 0 is valid the cycle after an accepted `start`;
  - with `outdata_ready` held high, the header streams at one byte per cycle.
- Data byte timing:
  - `mem_read` pulses in the cycle after `outdata_valid` falls (or after PRG/CHR entry);
  - a data byte is valid the cycle after `mem_rvalid`.
  - Rate is at best one byte per (read latency + 2) cycles.
- Backpressure: while valid && !ready, `outdata` and `outdata_valid` hold stable. `valid` never drops without a transfer.
- `done` rises the cycle after the final transfer.
- `busy` = 0 in the same cycle `done` = 1.

## Configuration

- Macro: `GAME_DUMPER_NES2_EN`.
- Defined: byte 7 = `{mapper_hi, 4'b1000}`, i.e. the NES 2.0 identifier in bits [3:2] = `2'b10`. Bytes 8–15 stay `00`.
- Undefined: byte 7 = `{mapper_hi, 4'b0000}` (plain iNES).
- No other behaviour changes.

## Test plan

- Minimal dump:
  - Stimulus: flags with prg 0, chr 0, mapper 0, mirroring 1; memory holds `addr[7:0]` at every address; sink always ready.
  - Response: header `4E 45 53 1A 01 01 01 00` followed by 8×`00`. Then 16384 PRG bytes from 0..`3FFF`, then 8192 CHR bytes from `200000..201FFF`. Total 24592 bytes, then `done` = 1.
- CHR-RAM game:
  - Stimulus: mapper 4 (lo = 4, hi = 0), prg_size 3, has_chr_ram = 1.
  - Response: bytes 4..7 = `08 00 40 00`. Exactly 131072 PRG bytes. No `mem_read` at or above `200000`. Then `done`.
- Backpressure:
  - Stimulus: `outdata_ready` toggled pseudo-randomly; memory latency randomized 1–5 cycles.
  - Response: stream identical to the always-ready run. `outdata` stable while stalled. Never more than one outstanding read.
- Reset mid-PRG:
  - Stimulus: assert `reset` after 100 PRG bytes, with a response due the next cycle.
  - Response: all outputs return to reset values. A later `start` emits a fresh header from byte 0.
- Restart and ignore:
  - Stimulus: `start` during CHR, then a second `start` in DONE.
  - Response: the first `start` has no effect. The second clears `done` and replays the full stream.
- NES 2.0 build:
  - Stimulus: compile with `GAME_DUMPER_NES2_EN`, mapper hi = 1.
  - Response: byte 7 = `18`.
